axis_rr_arbiter: RTL and testbench

// - N-to-1 AXI4-Stream packet arbiter; shares one master stream among NUM_SRC slave streams.
// - Round-robin grant, locked per packet: once granted, a source owns the output until
//   its TLAST beat handshakes.
// - Sits ahead of axis_if-based sinks; checked by the monitor BFM on the M side.

---
 rtl/axis_rr_arbiter_if.sv | 41 ++++
 rtl/axis_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_axis_rr_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/axis_rr_arbiter_if.sv
// Bundled stream signals between NUM_SRC AXI4-Stream sources, the arbiter and one sink.
// master: the arbiter side (drives M_* and S_TREADY); slave: the surrounding environment.
interface axis_rr_arbiter_if #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned TID_WIDTH   = 4,
  parameter int unsigned TDEST_WIDTH = 4,
  parameter int unsigned TUSER_WIDTH = 1
);
  localparam int unsigned KW = TDATA_WIDTH / 8;

  logic [NUM_SRC-1:0]             S_TVALID;
  logic [NUM_SRC-1:0]             S_TREADY;
  logic [NUM_SRC*TDATA_WIDTH-1:0] S_TDATA;
  logic [NUM_SRC*KW-1:0]          S_TSTRB;
  logic [NUM_SRC*KW-1:0]          S_TKEEP;
  logic [NUM_SRC-1:0]             S_TLAST;
  logic [NUM_SRC*TID_WIDTH-1:0]   S_TID;
  logic [NUM_SRC*TDEST_WIDTH-1:0] S_TDEST;
  logic [NUM_SRC*TUSER_WIDTH-1:0] S_TUSER;

  logic                   M_TVALID;
  logic                   M_TREADY;
  logic [TDATA_WIDTH-1:0] M_TDATA;
  logic [KW-1:0]          M_TSTRB;
  logic [KW-1:0]          M_TKEEP;
  logic                   M_TLAST;
  logic [TID_WIDTH-1:0]   M_TID;
  logic [TDEST_WIDTH-1:0] M_TDEST;
  logic [TUSER_WIDTH-1:0] M_TUSER;

  modport master (
    input  S_TVALID, S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER, M_TREADY,
    output S_TREADY, M_TVALID, M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER
  );

  modport slave (
    output S_TVALID, S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER, M_TREADY,
    input  S_TREADY, M_TVALID, M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI4-Stream packet arbiter: round-robin grant, ownership held until the TLAST handshake.
// Optional AXIS_ARB_TID_TAG_EN: M_TID carries the granted source index instead of S_TID.
module axis_rr_arbiter #(
  parameter int unsigned  NUM_SRC     = 4,
  parameter int unsigned  TDATA_WIDTH = 32,
  parameter int unsigned  TID_WIDTH   = 4,
  parameter int unsigned  TDEST_WIDTH = 4,
  parameter int unsigned  TUSER_WIDTH = 1,
  localparam int unsigned GW          = $clog2(NUM_SRC)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  axis_rr_arbiter_if.master bus,
  output logic [GW-1:0]     GRANT,
  output logic              BUSY
);
  localparam int unsigned KW = TDATA_WIDTH / 8;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic [KW-1:0]          strb;
    logic [KW-1:0]          keep;
    logic                   last;
    logic [TID_WIDTH-1:0]   id;
    logic [TDEST_WIDTH-1:0] dest;
    logic [TUSER_WIDTH-1:0] user;
  } beat_t;

  state_t      state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] winner_c;
  logic          found_c;
  logic          last_hs_c;
  int unsigned   idx;
  beat_t         s_beat [NUM_SRC];
  beat_t         m_beat_c;

  // Unpack the flat per-source vectors into one payload record per source.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign s_beat[i] = '{
      data: bus.S_TDATA[i*TDATA_WIDTH +: TDATA_WIDTH],
      strb: bus.S_TSTRB[i*KW +: KW],
      keep: bus.S_TKEEP[i*KW +: KW],
      last: bus.S_TLAST[i],
      id:   bus.S_TID[i*TID_WIDTH +: TID_WIDTH],
      dest: bus.S_TDEST[i*TDEST_WIDTH +: TDEST_WIDTH],
      user: bus.S_TUSER[i*TUSER_WIDTH +: TUSER_WIDTH]
    };
  end

  // First requester after the last owner, wrapping around.
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    idx      = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_SRC;
      if (!found_c && bus.S_TVALID[GW'(idx)]) begin
        found_c  = 1'b1;
        winner_c = GW'(idx);
      end
    end
  end

  assign m_beat_c  = s_beat[GRANT];
  assign last_hs_c = (state == LOCKED) && bus.S_TVALID[GRANT] && bus.M_TREADY && m_beat_c.last;

  // Zero-latency data path from the granted source; everything is gated off in IDLE.
  always_comb begin
    bus.S_TREADY = '0;
    bus.M_TVALID = 1'b0;
    if (state == LOCKED) begin
      bus.S_TREADY[GRANT] = bus.M_TREADY;
      bus.M_TVALID        = bus.S_TVALID[GRANT];
    end
  end

  assign bus.M_TDATA = m_beat_c.data;
  assign bus.M_TSTRB = m_beat_c.strb;
  assign bus.M_TKEEP = m_beat_c.keep;
  assign bus.M_TLAST = m_beat_c.last;
  assign bus.M_TDEST = m_beat_c.dest;
  assign bus.M_TUSER = m_beat_c.user;

`ifdef AXIS_ARB_TID_TAG_EN
  if (TID_WIDTH < GW) begin : g_tid_width_chk
    $error("axis_rr_arbiter: TID_WIDTH too narrow to carry the source index");
  end
  logic unused_tid;
  assign unused_tid = ^{bus.S_TID, m_beat_c.id};
  assign bus.M_TID  = TID_WIDTH'(GRANT);
`else
  assign bus.M_TID  = m_beat_c.id;
`endif

  // Arbitration happens only in IDLE; the owner is released on its TLAST handshake.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state  <= IDLE;
      rr_ptr <= GW'(NUM_SRC - 1);
      GRANT  <= '0;
      BUSY   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found_c) begin
            GRANT <= winner_c;
            BUSY  <= 1'b1;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (last_hs_c) begin
            rr_ptr <= GRANT;
            BUSY   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed, table-driven bench for axis_rr_arbiter (4 sources, 32-bit data).
// Expected M_TID follows AXIS_ARB_TID_TAG_EN when the bench is built with it.
module tb_axis_rr_arbiter;
  localparam logic [15:0] TID_C   = 16'h3F10;
  localparam logic [15:0] KEEP_C  = 16'h137F;
  localparam logic [15:0] STRB_C  = 16'hEC80;
  localparam logic [15:0] DEST_C  = 16'hBA98;
  localparam logic [3:0]  USER_C  = 4'b1010;

  logic       ACLK;
  logic       ARESETn;
  logic [1:0] GRANT;
  logic       BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  axis_rr_arbiter_if #(.NUM_SRC(4), .TDATA_WIDTH(32), .TID_WIDTH(4), .TDEST_WIDTH(4), .TUSER_WIDTH(1)) bus ();

  axis_rr_arbiter #(.NUM_SRC(4), .TDATA_WIDTH(32), .TID_WIDTH(4), .TDEST_WIDTH(4), .TUSER_WIDTH(1)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus),
    .GRANT   (GRANT),
    .BUSY    (BUSY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic       pre_rst;
    logic [3:0] valid;
    logic [3:0] last;
    logic [31:0] data;
    logic       mrdy;
    logic       exp_mv;
    logic [3:0] exp_srdy;
    logic       exp_busy;
    logic [1:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic pre_rst, input logic [3:0] valid, input logic [3:0] last,
                     input logic [31:0] data, input logic mrdy, input logic exp_mv,
                     input logic [3:0] exp_srdy, input logic exp_busy, input logic [1:0] exp_grant,
                     input logic [7:0] exp_data);
    vec_t v;
    v = '{pre_rst, valid, last, data, mrdy, exp_mv, exp_srdy, exp_busy, exp_grant, exp_data};
    tab.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] valid, input logic [3:0] last, input logic [31:0] data,
                       input logic mrdy);
    bus.S_TVALID = valid;
    bus.S_TLAST  = last;
    bus.M_TREADY = mrdy;
    for (int i = 0; i < 4; i++) bus.S_TDATA[i*32 +: 32] = {24'h0, data[i*8 +: 8]};
  endtask

  task automatic chk_ctrl(input string tag, input logic mv, input logic [3:0] srdy,
                          input logic busy, input logic [1:0] grant);
    chk({tag, ".m_tvalid"}, 32'(bus.M_TVALID), 32'(mv));
    chk({tag, ".s_tready"}, 32'(bus.S_TREADY), 32'(srdy));
    chk({tag, ".busy"},     32'(BUSY),         32'(busy));
    chk({tag, ".grant"},    32'(GRANT),        32'(grant));
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] g, input logic [7:0] d,
                          input logic [3:0] last);
    logic [3:0]  exp_tid;
    logic [12:0] exp_side;
`ifdef AXIS_ARB_TID_TAG_EN
    exp_tid = 4'(g);
`else
    exp_tid = TID_C[32'(g)*4 +: 4];
`endif
    exp_side = {KEEP_C[32'(g)*4 +: 4], STRB_C[32'(g)*4 +: 4], DEST_C[32'(g)*4 +: 4], USER_C[g]};
    chk({tag, ".m_tdata"}, bus.M_TDATA, {24'h0, d});
    chk({tag, ".m_tlast"}, 32'(bus.M_TLAST), 32'(last[g]));
    chk({tag, ".m_tid"},   32'(bus.M_TID), 32'(exp_tid));
    chk({tag, ".m_side"},  32'({bus.M_TKEEP, bus.M_TSTRB, bus.M_TDEST, bus.M_TUSER}), 32'(exp_side));
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETn = 1'b0;
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  initial begin
    ARESETn = 1'b0;
    bus.S_TID   = TID_C;
    bus.S_TKEEP = KEEP_C;
    bus.S_TSTRB = STRB_C;
    bus.S_TDEST = DEST_C;
    bus.S_TUSER = USER_C;
    bus.S_TDATA = '0;
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);

    // Single source 1, 3 beats, with one cycle where it withholds valid mid-packet.
    add(0, 4'b0010, 4'b0000, 32'h0000A100, 1, 0, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b0010, 4'b0000, 32'h0000A100, 1, 1, 4'b0010, 1, 1, 8'hA1);
    add(0, 4'b0000, 4'b0000, 32'h0000A200, 1, 0, 4'b0010, 1, 1, 8'h00);
    add(0, 4'b0010, 4'b0000, 32'h0000A200, 1, 1, 4'b0010, 1, 1, 8'hA2);
    add(0, 4'b0010, 4'b0010, 32'h0000A300, 1, 1, 4'b0010, 1, 1, 8'hA3);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 4'b0000, 0, 1, 8'h00);
    // All four sources from reset, 2-beat packets; source 0 queues a second packet.
    add(1, 4'b1111, 4'b0000, 32'h30201000, 1, 0, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b1111, 4'b0000, 32'h30201000, 1, 1, 4'b0001, 1, 0, 8'h00);
    add(0, 4'b1111, 4'b0001, 32'h30201001, 1, 1, 4'b0001, 1, 0, 8'h01);
    add(0, 4'b1111, 4'b0000, 32'h30201002, 1, 0, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b1111, 4'b0000, 32'h30201002, 1, 1, 4'b0010, 1, 1, 8'h10);
    add(0, 4'b1111, 4'b0010, 32'h30201102, 1, 1, 4'b0010, 1, 1, 8'h11);
    add(0, 4'b1101, 4'b0000, 32'h30200002, 1, 0, 4'b0000, 0, 1, 8'h00);
    add(0, 4'b1101, 4'b0000, 32'h30200002, 1, 1, 4'b0100, 1, 2, 8'h20);
    add(0, 4'b1101, 4'b0100, 32'h30210002, 1, 1, 4'b0100, 1, 2, 8'h21);
    add(0, 4'b1001, 4'b0000, 32'h30000002, 1, 0, 4'b0000, 0, 2, 8'h00);
    add(0, 4'b1001, 4'b0000, 32'h30000002, 1, 1, 4'b1000, 1, 3, 8'h30);
    add(0, 4'b1001, 4'b1000, 32'h31000002, 1, 1, 4'b1000, 1, 3, 8'h31);
    add(0, 4'b0001, 4'b0000, 32'h00000002, 1, 0, 4'b0000, 0, 3, 8'h00);
    add(0, 4'b0001, 4'b0000, 32'h00000002, 1, 1, 4'b0001, 1, 0, 8'h02);
    add(0, 4'b0001, 4'b0001, 32'h00000003, 1, 1, 4'b0001, 1, 0, 8'h03);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 4'b0000, 0, 0, 8'h00);
    // Source 2 stalled by M_TREADY 1,0,0,1 while source 0 waits.
    add(0, 4'b0100, 4'b0000, 32'h00B00000, 1, 0, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b0101, 4'b0000, 32'h00B000C0, 1, 1, 4'b0100, 1, 2, 8'hB0);
    add(0, 4'b0101, 4'b0100, 32'h00B100C0, 0, 1, 4'b0000, 1, 2, 8'hB1);
    add(0, 4'b0101, 4'b0100, 32'h00B100C0, 0, 1, 4'b0000, 1, 2, 8'hB1);
    add(0, 4'b0101, 4'b0100, 32'h00B100C0, 1, 1, 4'b0100, 1, 2, 8'hB1);
    add(0, 4'b0001, 4'b0001, 32'h000000C0, 1, 0, 4'b0000, 0, 2, 8'h00);
    add(0, 4'b0001, 4'b0001, 32'h000000C0, 1, 1, 4'b0001, 1, 0, 8'hC0);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 4'b0000, 0, 0, 8'h00);

    // Values held during reset.
    repeat (3) @(negedge ACLK);
    #2 chk_ctrl("in_reset", 0, 4'b0000, 0, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      #2 chk_ctrl("idle", 0, 4'b0000, 0, 0);
    end

    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].pre_rst) do_reset();
      @(negedge ACLK);
      drive(tab[i].valid, tab[i].last, tab[i].data, tab[i].mrdy);
      #2;
      chk_ctrl($sformatf("vec%0d", i), tab[i].exp_mv, tab[i].exp_srdy, tab[i].exp_busy, tab[i].exp_grant);
      if (tab[i].exp_mv) chk_beat($sformatf("vec%0d", i), tab[i].exp_grant, tab[i].exp_data, tab[i].last);
    end

    // Source 3 packet of 4 beats, reset asserted while beat 2 is presented.
    @(negedge ACLK);
    drive(4'b1000, 4'b0000, 32'hD0000000, 1'b1);
    #2 chk_ctrl("rst_seq.idle", 0, 4'b0000, 0, 0);
    @(negedge ACLK);
    #2 chk_ctrl("rst_seq.b1", 1, 4'b1000, 1, 3);
    chk_beat("rst_seq.b1", 2'd3, 8'hD0, 4'b0000);
    @(negedge ACLK);
    drive(4'b1000, 4'b0000, 32'hD1000000, 1'b1);
    #2 chk_ctrl("rst_seq.b2", 1, 4'b1000, 1, 3);
    #1 ARESETn = 1'b0;
    #1 chk_ctrl("rst_seq.async", 0, 4'b0000, 0, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    drive(4'b1001, 4'b0001, 32'hD10000E0, 1'b1);
    #2 chk_ctrl("rst_seq.rearb", 0, 4'b0000, 0, 0);
    @(negedge ACLK);
    #2 chk_ctrl("rst_seq.src0", 1, 4'b0001, 1, 0);
    chk_beat("rst_seq.src0", 2'd0, 8'hE0, 4'b0001);
    @(negedge ACLK);
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    #2 chk_ctrl("rst_seq.done", 0, 4'b0000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
